// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side logic.
// Holds the drain controller state encoding, the skid buffer depth and the
// default data width that must agree with the FIFO instance it reads from.
package fifo_pkg;

   // Default data word width, kept identical to the FIFO's default width
   localparam int FIFO_WIDTH = 32;

   // Number of entries in the output skid buffer
   localparam int SKID_DEPTH = 2;

   // Drain controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } drainState_t;

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry valid/ready skid buffer.
// Entry 0 is always the head word presented downstream; entry 1 holds the
// word behind it. A push and a pop in the same cycle leave the count alone.
// Ports:
//   clk_r       : clock, rising edge
//   rst         : asynchronous reset, active-high
//   i_push      : write i_pushData into the buffer this cycle
//   i_pushData  : word to store
//   i_pop       : head word is consumed this cycle
//   o_bufCnt    : number of words held (0..2)
//   o_headData  : head word, stable until popped
module fifo_skid2
   import fifo_pkg::*;
#(
   parameter int width = FIFO_WIDTH
) (
   input  logic             clk_r,
   input  logic             rst,
   input  logic             i_push,
   input  logic [width-1:0] i_pushData,
   input  logic             i_pop,
   output logic [1:0]       o_bufCnt,
   output logic [width-1:0] o_headData
);

   logic [1:0]       r_cnt;
   logic [width-1:0] r_entry0;
   logic [width-1:0] r_entry1;
   logic             w_pop;
   logic             w_push;

   // A pop only means something when a word is held; a push is refused only
   // when both entries are full and nothing leaves in the same cycle.
   always_comb begin
      w_pop  = i_pop && (r_cnt != 2'd0);
      w_push = i_push && ((r_cnt != 2'(SKID_DEPTH)) || w_pop);
   end

   // Storage update. On a simultaneous push and pop the incoming word lands
   // in whichever slot becomes the tail after the head shifts out.
   always_ff @(posedge clk_r or posedge rst) begin
      if (rst) begin
         r_cnt    <= 2'd0;
         r_entry0 <= '0;
         r_entry1 <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_cnt == 2'd0) begin
                  r_entry0 <= i_pushData;
               end else begin
                  r_entry1 <= i_pushData;
               end
               r_cnt <= r_cnt + 2'd1;
            end
            2'b01: begin
               r_entry0 <= r_entry1;
               r_cnt    <= r_cnt - 2'd1;
            end
            2'b11: begin
               if (r_cnt == 2'd1) begin
                  r_entry0 <= i_pushData;
               end else begin
                  r_entry0 <= r_entry1;
                  r_entry1 <= i_pushData;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_bufCnt   = r_cnt;
   assign o_headData = r_entry0;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller for the synchronous FIFO.
// Pops a commanded number of words through the FIFO read port (one cycle
// read latency) and presents them on a valid/ready stream with a last-word
// marker, absorbing downstream backpressure in a two-entry skid buffer.
// Ports:
//   clk_r      : read-side clock, rising edge
//   rst        : asynchronous reset, active-high
//   start/len  : burst command, sampled only while idle
//   busy       : burst in progress
//   done       : one-cycle pulse when the burst completes
//   fifo_empty : FIFO empty flag
//   fifo_rd_en : FIFO pop request
//   fifo_data  : FIFO read data, valid the cycle after fifo_rd_en
//   m_valid/m_ready/m_data/m_last : output stream
module fifo_drain_ctrl
   import fifo_pkg::*;
#(
   parameter int width = FIFO_WIDTH,
   parameter int LEN_W = 16
) (
   input  logic             clk_r,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic [width-1:0] fifo_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [width-1:0] m_data,
   output logic             m_last
);

   drainState_t      r_state;
   logic [LEN_W-1:0] r_lenQ;
   logic [LEN_W-1:0] r_issuedCnt;
   logic [LEN_W-1:0] r_sentCnt;
   logic             r_inflight;
   logic             r_busy;
   logic             r_done;

   logic [1:0]       w_bufCnt;
   logic [width-1:0] w_headData;
   logic             w_pop;
   logic             w_rdEn;
   logic [2:0]       w_occupancy;
   logic [2:0]       w_limit;

   // The skid buffer is written only in the cycle the FIFO read data is
   // known to be valid, so fifo_data is never looked at otherwise.
   fifo_skid2 #(
      .width (width)
   ) u_skid (
      .clk_r      (clk_r),
      .rst        (rst),
      .i_push     (r_inflight),
      .i_pushData (fifo_data),
      .i_pop      (w_pop),
      .o_bufCnt   (w_bufCnt),
      .o_headData (w_headData)
   );

   // Pop rule: a read is issued only if the word it returns is guaranteed a
   // slot. Words held plus the read already in flight, minus the word leaving
   // this cycle, must stay below two. The comparison is rearranged as
   // (held + inflight) < (2 + pop) so it never goes negative.
   always_comb begin
      w_pop       = m_valid && m_ready;
      w_occupancy = {1'b0, w_bufCnt} + {2'b00, r_inflight};
      w_limit     = 3'(SKID_DEPTH) + {2'b00, w_pop};
      w_rdEn      = (r_state == RUN) && !fifo_empty &&
                    (r_issuedCnt < r_lenQ) && (w_occupancy < w_limit);
   end

   // Burst sequencing, counters and the registered busy/done outputs.
   // A start that arrives outside IDLE falls through the case untouched, so
   // it is dropped rather than queued. The state transitions are written
   // after the counter increments so a new burst always clears them.
   always_ff @(posedge clk_r or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_lenQ      <= '0;
         r_issuedCnt <= '0;
         r_sentCnt   <= '0;
         r_inflight  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_inflight <= w_rdEn;
         if (w_rdEn) begin
            r_issuedCnt <= r_issuedCnt + 1'b1;
         end
         if (w_pop) begin
            r_sentCnt <= r_sentCnt + 1'b1;
         end
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  if (len != '0) begin
                     r_state     <= RUN;
                     r_lenQ      <= len;
                     r_issuedCnt <= '0;
                     r_sentCnt   <= '0;
                     r_busy      <= 1'b1;
                  end else begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (w_pop && m_last) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Stream side: the head of the skid buffer is the current word, and the
   // last marker compares the words already sent with the latched length.
   always_comb begin
      m_valid = (w_bufCnt != 2'd0);
      m_data  = w_headData;
      m_last  = m_valid && (r_sentCnt == (r_lenQ - 1'b1));
   end

   assign fifo_rd_en = w_rdEn;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Testbench for fifo_drain_ctrl: a FIFO read-port model feeds the DUT, a
// scoreboard queue holds the words expected on the stream, and a monitor
// pops and compares them at every handshake.
module tb_fifo_drain_ctrl;

   localparam int WIDTH = 32;
   localparam int LEN_W = 16;

   logic             clk_r;
   logic             rst;
   logic             start;
   logic [LEN_W-1:0] len;
   logic             busy;
   logic             done;
   logic             fifo_empty;
   logic             fifo_rd_en;
   logic [WIDTH-1:0] fifo_data;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;
   logic             m_last;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             last;
   } expEntry_t;

   logic [WIDTH-1:0] fifoQ[$];
   expEntry_t        expQ[$];

   int total = 0;
   int bad   = 0;

   int cyc;
   int rdEnCount;
   int firstRdCyc;
   int lastRdCyc;
   int hsCount;
   int firstHsCyc;
   int lastHsCyc;
   int doneCount;
   int doneCyc;
   int mValidCount;
   int busyCount;
   logic busyAtDone;

   fifo_drain_ctrl #(
      .width (WIDTH),
      .LEN_W (LEN_W)
   ) dut (
      .clk_r      (clk_r),
      .rst        (rst),
      .start      (start),
      .len        (len),
      .busy       (busy),
      .done       (done),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_data  (fifo_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last)
   );

   // Free-running clock
   initial clk_r = 1'b0;
   always #5 clk_r = ~clk_r;

   // FIFO read port model: one cycle latency, garbage when not reading
   always @(posedge clk_r) begin
      if (fifo_rd_en && (fifoQ.size() > 0)) begin
         fifo_data <= fifoQ.pop_front();
      end else begin
         fifo_data <= 32'hDEAD_BEEF;
      end
      fifo_empty <= (fifoQ.size() == 0);
   end

   // Monitor: scoreboard at each handshake, invariants, and per-cycle stats
   always @(negedge clk_r) begin
      expEntry_t e;
      cyc++;
      if (!rst) begin
         if (fifo_empty) begin
            total++;
            if (fifo_rd_en !== 1'b0) begin
               bad++;
               $display("[TB] FAIL rd_while_empty cyc=%0d got rd_en=%b want 0", cyc, fifo_rd_en);
            end
         end
         if (fifo_rd_en) begin
            rdEnCount++;
            if (firstRdCyc < 0) firstRdCyc = cyc;
            lastRdCyc = cyc;
         end
         if (m_valid) mValidCount++;
         if (busy) busyCount++;
         if (done) begin
            doneCount++;
            doneCyc    = cyc;
            busyAtDone = busy;
         end
         if (m_valid && m_ready) begin
            total++;
            hsCount++;
            if (firstHsCyc < 0) firstHsCyc = cyc;
            if (m_last) lastHsCyc = cyc;
            if (expQ.size() == 0) begin
               bad++;
               $display("[TB] FAIL extra_word got data=%h last=%b want no word", m_data, m_last);
            end else begin
               e = expQ.pop_front();
               if ((m_data !== e.data) || (m_last !== e.last)) begin
                  bad++;
                  $display("[TB] FAIL stream_word got data=%h last=%b want data=%h last=%b",
                           m_data, m_last, e.data, e.last);
               end
            end
         end
      end
   end

   task automatic clearStats();
      cyc        = -1;
      rdEnCount  = 0;
      firstRdCyc = -1;
      lastRdCyc  = -1;
      hsCount    = 0;
      firstHsCyc = -1;
      lastHsCyc  = -1;
      doneCount  = 0;
      doneCyc    = -1;
      mValidCount = 0;
      busyCount  = 0;
      busyAtDone = 1'b1;
   endtask

   task automatic preload(input logic [WIDTH-1:0] base, input int n);
      @(posedge clk_r); #1;
      for (int i = 0; i < n; i++) fifoQ.push_back(base + WIDTH'(i));
      if (n > 0) fifo_empty = 1'b0;
   endtask

   // Pulse start for one cycle; optionally expect the first n FIFO words
   task automatic applyStimulus(input int n, input bit expectFromFifo);
      expEntry_t e;
      @(posedge clk_r); #1;
      start = 1'b1;
      len   = LEN_W'(n);
      if (expectFromFifo) begin
         for (int i = 0; i < n; i++) begin
            e.data = fifoQ[i];
            e.last = (i == n - 1);
            expQ.push_back(e);
         end
      end
      clearStats();
      @(posedge clk_r); #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input int maxCycles);
      int n = 0;
      while ((doneCount == 0) && (n < maxCycles)) begin
         @(posedge clk_r); #1;
         n++;
      end
      total++;
      if (doneCount == 0) begin
         bad++;
         $display("[TB] FAIL done_timeout got no done within %0d cycles", maxCycles);
      end
      repeat (3) @(posedge clk_r);
      #1;
   endtask

   task automatic checkOutput(input string name, input int got, input int want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic test_reset();
      @(posedge clk_r); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk_r);
      #1;
      total++;
      if ({busy, done, fifo_rd_en, m_valid, m_last} !== 5'b0) begin
         bad++;
         $display("[TB] FAIL reset_flags got=%b want=00000", {busy, done, fifo_rd_en, m_valid, m_last});
      end
      total++;
      if (m_data !== '0) begin
         bad++;
         $display("[TB] FAIL reset_data got=%h want=0", m_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_base_burst();
      m_ready = 1'b1;
      preload(32'hA0, 4);
      applyStimulus(4, 1'b1);
      waitDone(40);
      checkOutput("base_first_rd", firstRdCyc, 1);
      checkOutput("base_rd_count", rdEnCount, 4);
      checkOutput("base_last_rd", lastRdCyc, 4);
      checkOutput("base_words", hsCount, 4);
      checkOutput("base_consecutive", lastHsCyc - firstHsCyc, 3);
      checkOutput("base_done_latency", doneCyc, lastHsCyc + 1);
      checkOutput("base_done_count", doneCount, 1);
      checkOutput("base_busy_at_done", int'(busyAtDone), 0);
      checkOutput("base_left", expQ.size(), 0);
   endtask

   task automatic test_backpressure();
      int n = 0;
      m_ready = 1'b0;
      preload(32'hA0, 6);
      applyStimulus(6, 1'b1);
      while (!m_valid && (n < 20)) begin
         @(posedge clk_r); #1;
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         total++;
         if ((m_valid !== 1'b1) || (m_data !== 32'hA0)) begin
            bad++;
            $display("[TB] FAIL bp_hold got valid=%b data=%h want valid=1 data=000000a0", m_valid, m_data);
         end
         @(posedge clk_r); #1;
      end
      checkOutput("bp_rd_stopped", rdEnCount, 2);
      m_ready = 1'b1;
      waitDone(60);
      checkOutput("bp_words", hsCount, 6);
      checkOutput("bp_rd_count", rdEnCount, 6);
      checkOutput("bp_done_count", doneCount, 1);
      checkOutput("bp_left", expQ.size(), 0);
   endtask

   task automatic test_empty_fifo();
      expEntry_t e;
      m_ready = 1'b1;
      applyStimulus(3, 1'b0);
      for (int w = 0; w < 3; w++) begin
         repeat (4) @(posedge clk_r);
         #1;
         fifoQ.push_back(32'hC0 + WIDTH'(w));
         e.data = 32'hC0 + WIDTH'(w);
         e.last = (w == 2);
         expQ.push_back(e);
         fifo_empty = 1'b0;
      end
      waitDone(60);
      checkOutput("empty_words", hsCount, 3);
      checkOutput("empty_rd_count", rdEnCount, 3);
      checkOutput("empty_done_count", doneCount, 1);
      checkOutput("empty_left", expQ.size(), 0);
   endtask

   task automatic test_zero_length();
      m_ready = 1'b1;
      preload(32'hE0, 2);
      applyStimulus(0, 1'b0);
      repeat (5) @(posedge clk_r);
      #1;
      checkOutput("zero_done_cyc", doneCyc, 1);
      checkOutput("zero_done_count", doneCount, 1);
      checkOutput("zero_rd_count", rdEnCount, 0);
      checkOutput("zero_valid_count", mValidCount, 0);
      checkOutput("zero_busy_count", busyCount, 0);
      fifoQ.delete();
      fifo_empty = 1'b1;
   endtask

   task automatic test_start_while_busy();
      m_ready = 1'b1;
      preload(32'hD0, 7);
      applyStimulus(5, 1'b1);
      @(posedge clk_r); #1;
      start = 1'b1;
      len   = LEN_W'(2);
      @(posedge clk_r); #1;
      start = 1'b0;
      waitDone(60);
      repeat (4) @(posedge clk_r);
      #1;
      checkOutput("busy_words", hsCount, 5);
      checkOutput("busy_rd_count", rdEnCount, 5);
      checkOutput("busy_done_count", doneCount, 1);
      checkOutput("busy_fifo_left", fifoQ.size(), 2);
      checkOutput("busy_left", expQ.size(), 0);
      fifoQ.delete();
      fifo_empty = 1'b1;
   endtask

   task automatic test_reset_mid_burst();
      int n = 0;
      m_ready = 1'b1;
      preload(32'hB0, 5);
      applyStimulus(4, 1'b1);
      while ((hsCount < 2) && (n < 20)) begin
         @(posedge clk_r); #1;
         n++;
      end
      checkOutput("rmb_two_words", hsCount, 2);
      rst = 1'b1;
      expQ.delete();
      #1;
      total++;
      if ({busy, done, fifo_rd_en, m_valid, m_last} !== 5'b0 || m_data !== '0) begin
         bad++;
         $display("[TB] FAIL rmb_outputs got flags=%b data=%h want 0", {busy, done, fifo_rd_en, m_valid, m_last}, m_data);
      end
      @(posedge clk_r); #1;
      rst = 1'b0;
      @(posedge clk_r); #1;
      total++;
      if ({busy, done, m_valid} !== 3'b0) begin
         bad++;
         $display("[TB] FAIL rmb_idle got busy/done/valid=%b want 000", {busy, done, m_valid});
      end
      checkOutput("rmb_fifo_left", fifoQ.size(), 1);
      applyStimulus(1, 1'b1);
      waitDone(40);
      checkOutput("rmb_words", hsCount, 1);
      checkOutput("rmb_done_count", doneCount, 1);
      checkOutput("rmb_left", expQ.size(), 0);
   endtask

   initial begin
      rst        = 1'b0;
      start      = 1'b0;
      len        = '0;
      m_ready    = 1'b0;
      fifo_empty = 1'b1;
      fifo_data  = '0;
      clearStats();
      #2;
      rst = 1'b1;
      test_reset();
      test_base_burst();
      test_backpressure();
      test_empty_fifo();
      test_zero_length();
      test_start_while_busy();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
